bounce_rect_engine: RTL

- Animated-sprite stage sitting directly upstream of the TinyVGA pixel-colour assignment in the tt_um top.
- Consumes the sync generator's vsync, display_on, hpos and vpos.
- Holds a rectangle position that moves once per frame and bounces off the active-area edges.
- Produces the 2-bit R/G/B for the current pixel. The colour cycles through an 8-entry palette on every bounce.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/bounce_axis.sv | 59 +++++
 rtl/bounce_rect_engine.sv | 97 +++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: active-area defaults, rgb222 colour type,
// bounce palette and axis direction encoding.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int POS_W        = 10;

  typedef logic [5:0] rgb222_t;

  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

  // Packed so that index 0 is the rightmost entry.
  localparam logic [7:0][5:0] PALETTE = {
    6'b10_10_10, 6'b11_11_11, 6'b11_00_11, 6'b00_11_11,
    6'b11_11_00, 6'b00_11_00, 6'b11_00_00, 6'b00_00_11
  };

  function automatic rgb222_t pal_lookup(input logic [2:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing rectangle: position and direction, stepping on
// each enabled tick and clamping to [0, LIMIT-SIZE] with a reflection.
module bounce_axis
  import vga_pkg::*;
#(
  parameter int LIMIT = 640,
  parameter int SIZE  = 100,
  parameter int START = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_en,
  input  logic [2:0]       step,
  output logic [POS_W-1:0] pos,
  output logic             hit
);

  localparam logic [POS_W:0] MAXP = (POS_W+1)'(LIMIT - SIZE);

  logic [POS_W-1:0] r_pos;
  dir_t             r_dir;
  logic [POS_W:0]   w_pos_ext;
  logic [POS_W:0]   w_step_ext;
  logic [POS_W:0]   w_sum;
  logic [POS_W:0]   w_diff;
  logic             w_edge;

  assign w_pos_ext  = {1'b0, r_pos};
  assign w_step_ext = {{(POS_W-2){1'b0}}, step};
  assign w_sum      = w_pos_ext + w_step_ext;
  assign w_diff     = w_pos_ext - w_step_ext;

  // A zero step never reaches an edge, even when already sitting on one.
  always_comb begin
    w_edge = 1'b0;
    if (step != 3'd0) begin
      if (r_dir == DIR_POS) w_edge = (w_sum >= MAXP);
      else                  w_edge = (w_pos_ext <= w_step_ext);
    end
  end

  assign hit = tick_en && w_edge;
  assign pos = r_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= POS_W'(START);
      r_dir <= DIR_POS;
    end else if (tick_en) begin
      if (w_edge) begin
        r_pos <= (r_dir == DIR_POS) ? MAXP[POS_W-1:0] : '0;
        r_dir <= (r_dir == DIR_POS) ? DIR_NEG : DIR_POS;
      end else begin
        r_pos <= (r_dir == DIR_POS) ? w_sum[POS_W-1:0] : w_diff[POS_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bounce_rect_engine.sv
// Bouncing-rectangle sprite: moves once per frame on the vsync leading edge,
// recolours on every bounce, and paints the current pixel combinationally.
module bounce_rect_engine
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE  = H_ACTIVE_DEF,
  parameter int   V_ACTIVE  = V_ACTIVE_DEF,
  parameter int   RECT_W    = 100,
  parameter int   RECT_H    = 100,
  parameter int   X0        = 100,
  parameter int   Y0        = 100,
  parameter logic VS_ACTIVE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             display_on,
  input  logic [POS_W-1:0] pix_x,
  input  logic [POS_W-1:0] pix_y,
  input  logic [2:0]       speed,
  input  logic             pause,
  output logic [1:0]       R,
  output logic [1:0]       G,
  output logic [1:0]       B,
  output logic [POS_W-1:0] rect_x,
  output logic [POS_W-1:0] rect_y,
  output logic [7:0]       bounce_count
);

  logic           r_vs_q;
  logic [2:0]     r_pal_idx;
  logic [7:0]     r_bounce_cnt;
  logic           w_tick;
  logic           w_tick_en;
  logic           w_hit_x;
  logic           w_hit_y;
  logic           w_inside;
  rgb222_t        w_rgb;
  logic [POS_W:0] w_px, w_py, w_rx, w_ry;

  assign w_tick    = (vsync == VS_ACTIVE) && (r_vs_q != VS_ACTIVE);
  assign w_tick_en = w_tick && !pause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vs_q <= ~VS_ACTIVE;
    else        r_vs_q <= vsync;
  end

  bounce_axis #(.LIMIT(H_ACTIVE), .SIZE(RECT_W), .START(X0)) u_axis_x (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_en(w_tick_en),
    .step   (speed),
    .pos    (rect_x),
    .hit    (w_hit_x)
  );

  bounce_axis #(.LIMIT(V_ACTIVE), .SIZE(RECT_H), .START(Y0)) u_axis_y (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_en(w_tick_en),
    .step   (speed),
    .pos    (rect_y),
    .hit    (w_hit_y)
  );

  // A corner hit on both axes in one tick is a single bounce event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pal_idx    <= 3'd0;
      r_bounce_cnt <= 8'd0;
    end else if (w_hit_x || w_hit_y) begin
      r_pal_idx    <= r_pal_idx + 3'd1;
      r_bounce_cnt <= r_bounce_cnt + 8'd1;
    end
  end

  assign bounce_count = r_bounce_cnt;

  assign w_px = {1'b0, pix_x};
  assign w_py = {1'b0, pix_y};
  assign w_rx = {1'b0, rect_x};
  assign w_ry = {1'b0, rect_y};

  assign w_inside = (w_px >= w_rx) && (w_px < w_rx + (POS_W+1)'(RECT_W)) &&
                    (w_py >= w_ry) && (w_py < w_ry + (POS_W+1)'(RECT_H));

  always_comb begin
    w_rgb = 6'b0;
    if (display_on && w_inside) w_rgb = pal_lookup(r_pal_idx);
  end

  assign R = w_rgb[5:4];
  assign G = w_rgb[3:2];
  assign B = w_rgb[1:0];

endmodule
